// File: rtl/cnt_seq_pkg.sv
// ============================================================================
// Module   : cnt_seq_pkg
// Purpose  : Shared types and constants for the cnt_seq sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 255;
  localparam int PRE_W        = 8;

  // Segment order {A,B,C,D,E,F,G}, active high; entry 0 is the rightmost.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

`default_nettype wire

// File: rtl/cnt_seq_if.sv
// ============================================================================
// Module   : cnt_seq_if
// Purpose  : Front-panel control and count/status bundle for cnt_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnt_seq_if;
  logic       Start;
  logic       Stop;
  logic       Load;
  logic [3:0] Din;
  logic [3:0] Limit;
  logic       Dir;
  logic       Wrap;
  logic [3:0] Q;
  logic       Tc;
  logic       Run;
  logic       Done;

  modport master (
    output Start, Stop, Load, Din, Limit, Dir, Wrap,
    input  Q, Tc, Run, Done
  );

  modport slave (
    input  Start, Stop, Load, Din, Limit, Dir, Wrap,
    output Q, Tc, Run, Done
  );
endinterface

`default_nettype wire

// File: rtl/cnt_seq_seg7_dec.sv
// ============================================================================
// Module   : seg7_dec
// Purpose  : Hex value to active-high seven-segment glyph {A..G}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_dec
  import cnt_seq_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[value];

endmodule

`default_nettype wire

// File: rtl/cnt_seq.sv
// ============================================================================
// Module   : cnt_seq
// Purpose  : Run/pause/one-shot sequencer owning the 4-bit count register.
//            Optional segment outputs A..G when CNT_SEQ_SEG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_seq
  import cnt_seq_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic     Clk,
  input  logic     Clr,
  cnt_seq_if.slave bus
`ifdef CNT_SEQ_SEG_EN
  ,
  output logic     A,
  output logic     B,
  output logic     C,
  output logic     D,
  output logic     E,
  output logic     F,
  output logic     G
`endif
);

  localparam int PRESCALE_C = (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN :
                              (PRESCALE > PRESCALE_MAX) ? PRESCALE_MAX : PRESCALE;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_C - 1);

  state_t           state_q, state_d;
  logic [3:0]       q_q, q_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             at_term;

  assign tick    = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign at_term = bus.Dir ? (q_q >= bus.Limit) : (q_q == 4'd0);

  // Priority chain: Load, then Stop, then Start, then normal counting.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (bus.Load) begin
      q_d   = bus.Din;
      pre_d = '0;
    end else if (bus.Stop) begin
      case (state_q)
        ST_RUN:            state_d = ST_PAUSE;
        ST_PAUSE, ST_DONE: state_d = ST_IDLE;
        default:           state_d = state_q;
      endcase
    end else if (bus.Start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      case (state_q)
        ST_IDLE: pre_d = '0;
        ST_DONE: begin
          pre_d = '0;
          q_d   = bus.Dir ? 4'd0 : bus.Limit;
        end
        default: pre_d = pre_q;
      endcase
    end else if (tick) begin
      pre_d = '0;
      if (at_term) begin
        tc_d = 1'b1;
        if (bus.Wrap) q_d = bus.Dir ? 4'd0 : bus.Limit;
        else          state_d = ST_DONE;
      end else begin
        q_d = bus.Dir ? (q_q + 4'd1) : (q_q - 4'd1);
      end
    end else if (state_q == ST_RUN) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      q_q     <= 4'd0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Tc   = tc_q;
  assign bus.Run  = (state_q == ST_RUN);
  assign bus.Done = (state_q == ST_DONE);

`ifdef CNT_SEQ_SEG_EN
  logic [6:0] seg_d, seg_q;

  // Decoding q_d lets the segments update on the same edge as Q.
  seg7_dec u_seg7_dec (
    .value (q_d),
    .seg   (seg_d)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) seg_q <= SEG_GLYPH[0];
    else     seg_q <= seg_d;
  end

  assign {A, B, C, D, E, F, G} = seg_q;
`endif

endmodule

`default_nettype wire

// File: doc/cnt_seq.md
# cnt_seq

Sequencing controller for the 4-bit counter/seven-segment datapath: owns the count register and decides when it steps, in which direction, where it wraps or stops, and when it may be loaded. A prescaler converts the system clock into count ticks, and a four-state FSM arbitrates the Start/Stop/Load controls. It sits between front-panel control inputs and the digit display, and replaces free-running counting with controlled run/pause/one-shot operation.

## Interface
- PRESCALE, 4: clocks per count tick; legal range 1..255.
- Clk  input  1  system clock; all state changes on the rising edge.
- Clr  input  1  asynchronous, active-high reset.
- Start  input  1  run request, level-sampled each cycle.
- Stop  input  1  pause/abort request, level-sampled each cycle.
- Load  input  1  synchronous load of Din into Q.
- Din  input  4  load value.
- Limit  input  4  terminal value; the count range is 0..Limit.
- Dir  input  1  1 = up, 0 = down; sampled on each tick.
- Wrap  input  1  1 = wrap at terminal, 0 = one-shot (stop at terminal).
- Q  output  4  count value, registered.
- Tc  output  1  terminal-count pulse, registered, one cycle wide.
- Run  output  1  high while in RUN, registered.
- Done  output  1  high while in DONE, registered.
- A, B, C, D, E, F, G  output  1 each  seven-segment drive for Q; present only with CNT_SEQ_SEG_EN.

## Operation
- States:
  - IDLE: waits for Start.
  - RUN: counts on ticks.
  - PAUSE: holds Q and the prescaler value.
  - DONE: reached only in one-shot mode.
- Control priority in any one cycle: Load > Stop > Start. When Start and Stop are high together, Stop wins.
- Load (any state):
  - Q <= Din, prescaler <= 0.
  - State is unchanged and Tc = 0.
  - Din > Limit is accepted as is.
- Prescaler:
  - Counts 0..PRESCALE-1 only while in RUN.
  - tick = (prescaler == PRESCALE-1) and state is RUN.
- Transitions:
  - IDLE + Start -> RUN, prescaler <= 0.
  - RUN + Stop -> PAUSE.
  - PAUSE + Start -> RUN; the prescaler resumes from its held value.
  - PAUSE + Stop -> IDLE; Q is kept.
  - DONE + Start -> RUN, with Q <= 0 if Dir = 1, or Q <= Limit if Dir = 0.
  - DONE + Stop -> IDLE.
- Up tick:
  - If Q >= Limit: terminal. Tc = 1. With Wrap = 1, Q <= 0 and the state stays RUN. With Wrap = 0, Q is held and the state goes to DONE.
  - Otherwise Q <= Q + 1.
- Down tick:
  - If Q == 0: terminal. Tc = 1. With Wrap = 1, Q <= Limit. With Wrap = 0, Q is held and the state goes to DONE.
  - Otherwise Q <= Q - 1.
- Limit = 0 in up/wrap mode: every tick is terminal, so Q stays 0 and Tc fires every tick.
- A Stop in the same cycle as a tick wins: no step and no Tc.
- Arithmetic is 4-bit unsigned. Q never leaves 0..15 and never wraps through 15 -> 0 except via the terminal rule.

## Timing
- Reset values: Q = 0, state IDLE, prescaler 0, Tc = 0, Run = 0, Done = 0. Segments show "0": A..F = 1, G = 0.
- Clr asserted mid-count forces the reset values immediately, independent of Clk.
- Start sampled at edge k: Run = 1 after edge k, and the first Q step happens at edge k + PRESCALE.
- Tc is high in exactly the cycle after the terminal edge, aligned with the Q update or hold.
- Done rises on the same edge as that Tc.
- Load takes effect on the sampling edge (1-cycle latency).
- With PRESCALE = 1, Q steps on every RUN cycle.

## Configuration
- CNT_SEQ_SEG_EN defined:
  - Ports A..G exist.
  - Driven by a registered decode of the next Q, so the segments change on the same edge as Q.
  - Active-high, standard hex glyphs 0-F; A = top, clockwise, G = middle.
- CNT_SEQ_SEG_EN undefined:
  - Ports and decoder are absent.
  - All other behaviour is identical.

## Structure
- cnt_seq_pkg holds:
  - the state typedef (IDLE, RUN, PAUSE, DONE);
  - the 16-entry 7-bit segment glyph constant table;
  - the PRESCALE bounds.
- One sub-module, seg7_dec: 4-bit value in, 7-bit segments out, using the package table. It is instantiated only under CNT_SEQ_SEG_EN.

## Test plan
- Reset release, then Start for 1 cycle with PRESCALE = 2, Dir = 1, Wrap = 1, Limit = 9 -> Q steps 0,1,...,9,0 every 2 clocks; Tc pulses once, on the 9 -> 0 edge.
- Dir = 1, Wrap = 0, Limit = 5 -> Q stops at 5, Tc pulses once, Done = 1, Run = 0. Then Start -> Q restarts from 0.
- Dir = 0, Wrap = 1, Limit = 3, Load Din = 2 -> Q = 2,1,0,3,2; Tc is seen on the 0 -> 3 edge.
- Stop at Q = 4 mid-prescale, hold PAUSE 10 clocks, then Start -> Q is still 4 and the step occurs after the remaining prescale count. Start and Stop together -> PAUSE.
- Load Din = 12 with Limit = 7 while up-counting -> next tick is terminal, Q = 0, Tc = 1. Load in the same cycle as a tick -> Q = Din, no Tc.
- Clr pulse with Q = 6 in RUN -> Q = 0, Run = 0 before the next edge. With CNT_SEQ_SEG_EN, segments for Q = 8 are 1111111 and for Q = 0 are 1111110.
